// File: rtl/ir_pkg.sv
// Shared definitions for the instruction prefetch queue and the control-unit decoder.
package ir_pkg;

    localparam int INSTR_W_DEF   = 16;
    localparam int OP_W_DEF      = 6;
    localparam int DEPTH_DEF     = 4;
    localparam int OPERAND_W_DEF = INSTR_W_DEF - OP_W_DEF;

    typedef logic [INSTR_W_DEF-1:0]   instr_t;
    typedef logic [OP_W_DEF-1:0]      opcode_t;
    typedef logic [OPERAND_W_DEF-1:0] operand_t;

    // Opcode is the most significant field of the instruction word.
    function automatic opcode_t get_opcode(input instr_t word);
        return word[INSTR_W_DEF-1 -: OP_W_DEF];
    endfunction

    // Operand is everything below the opcode field.
    function automatic operand_t get_operand(input instr_t word);
        return word[OPERAND_W_DEF-1:0];
    endfunction

endpackage

// File: rtl/ir_fifo.sv
// Circular buffer holding prefetched instruction words ahead of the IR.
module ir_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push_valid,
    input  logic [W-1:0]  push_data,
    output logic          push_ready,
    input  logic          pop_req,
    output logic          pop_fire,
    output logic [W-1:0]  head_data,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          push_fire;

    // Ready depends on registered occupancy only, so no input reaches it combinationally.
    assign push_ready = (count_reg != CW'(DEPTH));
    assign push_fire  = push_valid && push_ready && !flush;
    assign pop_fire   = pop_req && (count_reg != '0) && !flush;
    assign head_data  = mem[rd_ptr_reg];
    assign count      = count_reg;

    // Occupancy changes only when exactly one of push/pop happens.
    always_comb begin
        count_next = count_reg;
        if (push_fire && !pop_fire) begin
            count_next = count_reg + CW'(1);
        end else if (pop_fire && !push_fire) begin
            count_next = count_reg - CW'(1);
        end
    end

    // Storage is left unreset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally at power-of-two depth; flush empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_fire) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop_fire)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/ir_prefetch_queue.sv
// Prefetch queue feeding the instruction register and its decoded fields.
module ir_prefetch_queue
    import ir_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int OP_W    = OP_W_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [INSTR_W-1:0]         in_instr,
    output logic                       in_ready,
    input  logic                       ir_load,
    output logic                       ir_valid,
    output logic [OP_W-1:0]            opcode,
    output logic [INSTR_W-OP_W-1:0]    operand,
    output logic [$clog2(DEPTH+1)-1:0] q_count
);

    logic [INSTR_W-1:0] head_data;
    logic [INSTR_W-1:0] ir_reg;
    logic               ir_valid_reg;
    logic               pop_fire;

    ir_fifo #(
        .W     (INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .push_valid (in_valid),
        .push_data  (in_instr),
        .push_ready (in_ready),
        .pop_req    (ir_load),
        .pop_fire   (pop_fire),
        .head_data  (head_data),
        .count      (q_count)
    );

    // IR takes the head on a real pop; a load against an empty queue leaves a bubble.
    // Flush only invalidates: the IR contents are kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_reg       <= '0;
            ir_valid_reg <= 1'b0;
        end else if (flush) begin
            ir_valid_reg <= 1'b0;
        end else if (ir_load) begin
            if (pop_fire) begin
                ir_reg       <= head_data;
                ir_valid_reg <= 1'b1;
            end else begin
                ir_valid_reg <= 1'b0;
            end
        end
    end

    assign ir_valid = ir_valid_reg;

    // Default widths share the decoder's slicing helpers; other widths slice directly.
    generate
        if (INSTR_W == INSTR_W_DEF && OP_W == OP_W_DEF) begin : g_pkg_fields
            assign opcode  = get_opcode(ir_reg);
            assign operand = get_operand(ir_reg);
        end else begin : g_param_fields
            assign opcode  = ir_reg[INSTR_W-1 -: OP_W];
            assign operand = ir_reg[INSTR_W-OP_W-1:0];
        end
    endgenerate

endmodule
